// File: rtl/nn_weight_loader.sv
// Framed byte-stream loader for the relu_nn weights and biases.
// Shadow words are committed atomically only after the XOR checksum matches.
module nn_weight_loader #(
    parameter int         WIDTH  = 16,
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic [WIDTH-1:0] h1_w1,
    output logic [WIDTH-1:0] h1_w2,
    output logic [WIDTH-1:0] h1_bias,
    output logic [WIDTH-1:0] h2_w1,
    output logic [WIDTH-1:0] h2_w2,
    output logic [WIDTH-1:0] h2_bias,
    output logic [WIDTH-1:0] out_w1,
    output logic [WIDTH-1:0] out_w2,
    output logic [WIDTH-1:0] out_bias,
    output logic             weights_valid,
    output logic             load_done,
    output logic             load_err,
    output logic [7:0]       err_count
);

    localparam int BPW    = WIDTH / 8;
    localparam int NWORDS = 9;
    localparam int NBYTES = NWORDS * BPW;
    localparam int CW     = $clog2(NBYTES + 1);

    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;
    localparam logic [1:0] S_COMMIT  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       xor_q, xor_d;
    logic             match_q, match_d;
    logic [WIDTH-1:0] shadow_q [NWORDS];
    logic [WIDTH-1:0] shadow_d [NWORDS];
    logic [WIDTH-1:0] w_q [NWORDS];
    logic [WIDTH-1:0] w_d [NWORDS];
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [7:0]       errcnt_q, errcnt_d;

    logic          take;
    logic [CW-1:0] widx;

    assign in_ready = (state_q != S_COMMIT);
    assign take     = in_valid && in_ready;
    assign widx     = cnt_q / CW'(BPW);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        xor_d    = xor_q;
        match_d  = match_q;
        shadow_d = shadow_q;
        w_d      = w_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        errcnt_d = errcnt_q;
        // abort outranks both byte acceptance and the commit itself
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            xor_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (take && in_data == HEADER) begin
                        state_d = S_PAYLOAD;
                        cnt_d   = '0;
                        xor_d   = '0;
                    end
                end
                S_PAYLOAD: begin
                    if (take) begin
                        for (int i = 0; i < NWORDS; i++) begin
                            if (widx == CW'(i)) begin
                                shadow_d[i] = WIDTH'({shadow_q[i], in_data});
                            end
                        end
                        xor_d = xor_q ^ in_data;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == LAST) begin
                            state_d = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (take) begin
                        match_d = (in_data == xor_q);
                        state_d = S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    state_d = S_IDLE;
                    if (match_q) begin
                        w_d     = shadow_q;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                        if (errcnt_q != 8'hFF) begin
                            errcnt_d = errcnt_q + 8'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            xor_q    <= '0;
            match_q  <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
            for (int i = 0; i < NWORDS; i++) begin
                shadow_q[i] <= '0;
                w_q[i]      <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            xor_q    <= xor_d;
            match_q  <= match_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
            for (int i = 0; i < NWORDS; i++) begin
                shadow_q[i] <= shadow_d[i];
                w_q[i]      <= w_d[i];
            end
        end
    end

    assign h1_w1         = w_q[0];
    assign h1_w2         = w_q[1];
    assign h1_bias       = w_q[2];
    assign h2_w1         = w_q[3];
    assign h2_w2         = w_q[4];
    assign h2_bias       = w_q[5];
    assign out_w1        = w_q[6];
    assign out_w2        = w_q[7];
    assign out_bias      = w_q[8];
    assign weights_valid = valid_q;
    assign load_done     = done_q;
    assign load_err      = err_q;
    assign err_count     = errcnt_q;

endmodule
